// File: rtl/axi_pack.sv
// Shared AXI transaction types and helpers for the address-channel front end.
package axi_pack;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    localparam int PAGE_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_ERR
    } gen_state_t;

    // WRAP bursts are restricted to 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_beat_strb.sv
// Byte-lane strobe for one beat: lanes from the address offset up to the end
// of the size-aligned container.
module axi_beat_strb
    import axi_pack::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic [ADDR_W-1:0]   i_addr,
    input  size_t               i_size,
    output logic [DATA_W/8-1:0] o_strb
);

    localparam int NB = DATA_W / 8;

    logic [ADDR_W-1:0] w_s;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_end;

    always_comb begin
        w_s   = ADDR_W'(1) << i_size;
        w_off = i_addr & ADDR_W'(NB - 1);
        w_end = (w_off & ~(w_s - ADDR_W'(1))) + w_s;
        for (int i = 0; i < NB; i++) begin
            o_strb[i] = (ADDR_W'(i) >= w_off) && (ADDR_W'(i) < w_end);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into a registered per-beat address/strobe stream,
// rejecting protocol-violating commands with a one-cycle error pulse.
module axi_burst_addr_gen
    import axi_pack::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  len_t                cmd_len_i,
    input  size_t               cmd_size_i,
    input  burst_t              cmd_burst_i,
    input  logic [ID_W-1:0]     cmd_id_i,
    output logic                beat_valid_o,
    input  logic                beat_ready_i,
    output logic [ADDR_W-1:0]   beat_addr_o,
    output logic [DATA_W/8-1:0] beat_strb_o,
    output len_t                beat_idx_o,
    output logic                beat_last_o,
    output logic [ID_W-1:0]     beat_id_o,
    output logic                err_o,
    output logic [ID_W-1:0]     err_id_o
);

    localparam int NB     = DATA_W / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    gen_state_t        r_state;
    logic              r_beat_valid;
    logic              r_last;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [NB-1:0]     r_strb;
    len_t              r_idx;
    len_t              r_len;
    size_t             r_size;
    burst_t            r_burst;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_err_id;

    logic [ADDR_W-1:0] w_cmd_s;
    logic [ADDR_W-1:0] w_cmd_aligned;
    logic [ADDR_W-1:0] w_cmd_span;
    logic [ADDR_W-1:0] w_cmd_last_byte;
    logic [ADDR_W-1:0] w_cmd_wrap_lower;
    logic              w_cmd_legal;
    logic              w_cmd_ready;
    logic              w_cmd_accept;
    logic              w_beat_hs;

    always_comb begin
        w_cmd_s          = ONE << cmd_size_i;
        w_cmd_aligned    = cmd_addr_i & ~(w_cmd_s - ONE);
        w_cmd_span       = (ADDR_W'(cmd_len_i) + ONE) << cmd_size_i;
        w_cmd_last_byte  = w_cmd_aligned + w_cmd_span - ONE;
        w_cmd_wrap_lower = cmd_addr_i & ~(w_cmd_span - ONE);

        w_cmd_legal = 1'b1;
        if (cmd_burst_i == 2'b11) w_cmd_legal = 1'b0;
        if (int'(cmd_size_i) > NB_LOG) w_cmd_legal = 1'b0;
        if (cmd_burst_i == BURST_WRAP &&
            (!wrap_len_legal(cmd_len_i) || (cmd_addr_i & (w_cmd_s - ONE)) != '0))
            w_cmd_legal = 1'b0;
        if (cmd_burst_i == BURST_INCR &&
            w_cmd_last_byte[ADDR_W-1:PAGE_BITS] != cmd_addr_i[ADDR_W-1:PAGE_BITS])
            w_cmd_legal = 1'b0;
    end

    assign w_beat_hs    = r_beat_valid && beat_ready_i;
    assign w_cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_BURST && w_beat_hs && r_last);
    assign w_cmd_accept = cmd_valid_i && w_cmd_ready;

    // r_base holds the aligned start for INCR and the wrap boundary for WRAP.
    logic [ADDR_W-1:0] w_step_s;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_wrap_inc;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_sel_addr;
    len_t              w_idx_nxt;
    size_t             w_sel_size;
    logic [NB-1:0]     w_strb_nxt;

    always_comb begin
        w_step_s   = ONE << r_size;
        w_span     = (ADDR_W'(r_len) + ONE) << r_size;
        w_idx_nxt  = r_idx + len_t'(1);
        w_wrap_inc = r_addr + w_step_s;
        case (r_burst)
            BURST_INCR: w_next_addr = r_base + (ADDR_W'(w_idx_nxt) << r_size);
            BURST_WRAP: w_next_addr = (w_wrap_inc == r_base + w_span) ? r_base : w_wrap_inc;
            default:    w_next_addr = r_addr;
        endcase
        w_sel_addr = w_cmd_accept ? cmd_addr_i : w_next_addr;
        w_sel_size = w_cmd_accept ? cmd_size_i : r_size;
    end

    axi_beat_strb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_strb (
        .i_addr (w_sel_addr),
        .i_size (w_sel_size),
        .o_strb (w_strb_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat_valid <= 1'b0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_base       <= '0;
            r_strb       <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= BURST_FIXED;
            r_id         <= '0;
            r_err_id     <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_cmd_accept) begin
                if (w_cmd_legal) begin
                    r_state      <= ST_BURST;
                    r_beat_valid <= 1'b1;
                    r_addr       <= cmd_addr_i;
                    r_base       <= (cmd_burst_i == BURST_WRAP) ? w_cmd_wrap_lower : w_cmd_aligned;
                    r_strb       <= w_strb_nxt;
                    r_idx        <= '0;
                    r_last       <= (cmd_len_i == '0);
                    r_len        <= cmd_len_i;
                    r_size       <= cmd_size_i;
                    r_burst      <= cmd_burst_i;
                    r_id         <= cmd_id_i;
                end else begin
                    r_state      <= ST_ERR;
                    r_beat_valid <= 1'b0;
                    r_err        <= 1'b1;
                    r_err_id     <= cmd_id_i;
                end
            end else if (r_state == ST_BURST && w_beat_hs) begin
                if (r_last) begin
                    r_state      <= ST_IDLE;
                    r_beat_valid <= 1'b0;
                end else begin
                    r_addr <= w_next_addr;
                    r_strb <= w_strb_nxt;
                    r_idx  <= w_idx_nxt;
                    r_last <= (w_idx_nxt == r_len);
                end
            end else if (r_state == ST_ERR) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign cmd_ready_o  = w_cmd_ready;
    assign beat_valid_o = r_beat_valid;
    assign beat_addr_o  = r_addr;
    assign beat_strb_o  = r_strb;
    assign beat_idx_o   = r_idx;
    assign beat_last_o  = r_last;
    assign beat_id_o    = r_id;
    assign err_o        = r_err;
    assign err_id_o     = r_err_id;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen with hand-computed beat streams (DATA_W=64).
module tb_axi_burst_addr_gen;
    import axi_pack::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    len_t              cmd_len_i;
    size_t             cmd_size_i;
    burst_t            cmd_burst_i;
    logic [ID_W-1:0]   cmd_id_i;
    logic              beat_valid_o;
    logic              beat_ready_i;
    logic [ADDR_W-1:0] beat_addr_o;
    logic [NB-1:0]     beat_strb_o;
    len_t              beat_idx_o;
    logic              beat_last_o;
    logic [ID_W-1:0]   beat_id_o;
    logic              err_o;
    logic [ID_W-1:0]   err_id_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_burst_i  (cmd_burst_i),
        .cmd_id_i     (cmd_id_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_addr_o  (beat_addr_o),
        .beat_strb_o  (beat_strb_o),
        .beat_idx_o   (beat_idx_o),
        .beat_last_o  (beat_last_o),
        .beat_id_o    (beat_id_o),
        .err_o        (err_o),
        .err_id_o     (err_id_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_cmd(input logic [ADDR_W-1:0] addr, input len_t len, input size_t size,
                             input burst_t burst, input logic [ID_W-1:0] id);
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_size_i  = size;
        cmd_burst_i = burst;
        cmd_id_i    = id;
        cmd_valid_i = 1'b1;
    endtask

    // Present a command while idle, let it be accepted, then drop valid.
    task automatic issue(input string tag, input logic [ADDR_W-1:0] addr, input len_t len,
                         input size_t size, input burst_t burst, input logic [ID_W-1:0] id);
        drive_cmd(addr, len, size, burst, id);
        #1;
        chk({tag, "_cmd_rdy"}, cmd_ready_o, 1'b1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [ADDR_W-1:0] addr, input logic [NB-1:0] strb,
                               input len_t idx, input logic last, input logic [ID_W-1:0] id);
        chk({tag, "_vld"},  beat_valid_o, 1'b1);
        chk({tag, "_addr"}, beat_addr_o,  addr);
        chk({tag, "_strb"}, beat_strb_o,  strb);
        chk({tag, "_idx"},  beat_idx_o,   idx);
        chk({tag, "_last"}, beat_last_o,  last);
        chk({tag, "_id"},   beat_id_o,    id);
    endtask

    task automatic err_case(input string tag, input logic [ADDR_W-1:0] addr, input len_t len,
                            input size_t size, input burst_t burst, input logic [ID_W-1:0] id);
        issue(tag, addr, len, size, burst, id);
        chk({tag, "_err"},    err_o,        1'b1);
        chk({tag, "_err_id"}, err_id_o,     id);
        chk({tag, "_vld"},    beat_valid_o, 1'b0);
        chk({tag, "_rdy"},    cmd_ready_o,  1'b0);
        step();
        chk({tag, "_err_end"}, err_o,        1'b0);
        chk({tag, "_rdy_end"}, cmd_ready_o,  1'b1);
        chk({tag, "_vld_end"}, beat_valid_o, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_len_i    = '0;
        cmd_size_i   = '0;
        cmd_burst_i  = BURST_FIXED;
        cmd_id_i     = '0;
        beat_ready_i = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_vld",    beat_valid_o, 1'b0);
        chk("rst_last",   beat_last_o,  1'b0);
        chk("rst_err",    err_o,        1'b0);
        chk("rst_addr",   beat_addr_o,  '0);
        chk("rst_strb",   beat_strb_o,  '0);
        chk("rst_rdy",    cmd_ready_o,  1'b1);

        // INCR from an unaligned start
        issue("incr", 32'h1006, 8'd3, 3'd2, BURST_INCR, 4'd1);
        expect_beat("incr0", 32'h1006, 8'hC0, 8'd0, 1'b0, 4'd1); step();
        expect_beat("incr1", 32'h1008, 8'h0F, 8'd1, 1'b0, 4'd1); step();
        expect_beat("incr2", 32'h100C, 8'hF0, 8'd2, 1'b0, 4'd1); step();
        expect_beat("incr3", 32'h1010, 8'h0F, 8'd3, 1'b1, 4'd1); step();
        chk("incr_done_vld", beat_valid_o, 1'b0);

        issue("wrap", 32'h38, 8'd3, 3'd3, BURST_WRAP, 4'd2);
        expect_beat("wrap0", 32'h38, 8'hFF, 8'd0, 1'b0, 4'd2); step();
        expect_beat("wrap1", 32'h20, 8'hFF, 8'd1, 1'b0, 4'd2); step();
        expect_beat("wrap2", 32'h28, 8'hFF, 8'd2, 1'b0, 4'd2); step();
        expect_beat("wrap3", 32'h30, 8'hFF, 8'd3, 1'b1, 4'd2); step();
        chk("wrap_done_vld", beat_valid_o, 1'b0);

        issue("fixed", 32'h102, 8'd2, 3'd1, BURST_FIXED, 4'd5);
        expect_beat("fix0", 32'h102, 8'h0C, 8'd0, 1'b0, 4'd5); step();
        expect_beat("fix1", 32'h102, 8'h0C, 8'd1, 1'b0, 4'd5); step();
        expect_beat("fix2", 32'h102, 8'h0C, 8'd2, 1'b1, 4'd5); step();
        chk("fix_done_vld", beat_valid_o, 1'b0);

        err_case("e_4k",     32'hFF8, 8'd1, 3'd3, BURST_INCR, 4'd6);
        err_case("e_wlen",   32'h0,   8'd2, 3'd3, BURST_WRAP, 4'd7);
        err_case("e_size",   32'h0,   8'd0, 3'd4, BURST_INCR, 4'd8);
        err_case("e_rsv",    32'h0,   8'd0, 3'd0, 2'b11,      4'd9);
        err_case("e_walign", 32'h4,   8'd1, 3'd3, BURST_WRAP, 4'd10);

        // Page-edge cases that are legal
        issue("fix4k", 32'hFF8, 8'd1, 3'd3, BURST_FIXED, 4'd11);
        chk("fix4k_err", err_o, 1'b0);
        expect_beat("fix4k0", 32'hFF8, 8'hFF, 8'd0, 1'b0, 4'd11); step();
        expect_beat("fix4k1", 32'hFF8, 8'hFF, 8'd1, 1'b1, 4'd11); step();
        issue("incrpg", 32'hFF0, 8'd1, 3'd3, BURST_INCR, 4'd12);
        chk("incrpg_err", err_o, 1'b0);
        expect_beat("incrpg0", 32'hFF0, 8'hFF, 8'd0, 1'b0, 4'd12); step();
        expect_beat("incrpg1", 32'hFF8, 8'hFF, 8'd1, 1'b1, 4'd12); step();

        // Backpressure, then a new command overlapping the last beat
        issue("stall", 32'h2000, 8'd3, 3'd3, BURST_INCR, 4'd2);
        expect_beat("st0", 32'h2000, 8'hFF, 8'd0, 1'b0, 4'd2); step();
        expect_beat("st1", 32'h2008, 8'hFF, 8'd1, 1'b0, 4'd2);
        beat_ready_i = 1'b0;
        #1;
        chk("st_busy_rdy", cmd_ready_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_beat("st_hold", 32'h2008, 8'hFF, 8'd1, 1'b0, 4'd2);
        end
        beat_ready_i = 1'b1;
        step();
        expect_beat("st2", 32'h2010, 8'hFF, 8'd2, 1'b0, 4'd2); step();
        expect_beat("st3", 32'h2018, 8'hFF, 8'd3, 1'b1, 4'd2);
        drive_cmd(32'h3004, 8'd0, 3'd2, BURST_INCR, 4'd9);
        #1;
        chk("b2b_rdy", cmd_ready_o, 1'b1);
        step();
        cmd_valid_i = 1'b0;
        expect_beat("b2b0", 32'h3004, 8'hF0, 8'd0, 1'b1, 4'd9); step();
        chk("b2b_done_vld", beat_valid_o, 1'b0);

        // Reset in the middle of a burst
        issue("mrst", 32'h4000, 8'd7, 3'd2, BURST_INCR, 4'd3);
        expect_beat("mrst0", 32'h4000, 8'h0F, 8'd0, 1'b0, 4'd3); step();
        expect_beat("mrst1", 32'h4004, 8'hF0, 8'd1, 1'b0, 4'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_vld",    beat_valid_o, 1'b0);
        chk("mrst_rdy",    cmd_ready_o,  1'b1);
        chk("mrst_addr",   beat_addr_o,  '0);
        chk("mrst_strb",   beat_strb_o,  '0);
        chk("mrst_idx",    beat_idx_o,   '0);
        chk("mrst_last",   beat_last_o,  1'b0);
        chk("mrst_id",     beat_id_o,    '0);
        chk("mrst_err",    err_o,        1'b0);
        chk("mrst_err_id", err_id_o,     '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
